// File: rtl/grid_addr_gen.sv
// Raster-order address generator for a square lattice.
// Emits row/col/linear address with a valid/ready handshake.
module grid_addr_gen #(
   parameter int GRID_DIM      = 16*16,
   parameter int GRID_SIDE     = 16,
   parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
   parameter int COUNT_WIDTH   = $clog2(GRID_DIM/GRID_SIDE)
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic                     Ready_in,
   output logic                     Valid_out,
   output logic [ADDRESS_WIDTH-1:0] Addr_out,
   output logic [COUNT_WIDTH-1:0]   Row_out,
   output logic [COUNT_WIDTH-1:0]   Col_out,
   output logic                     Last_out,
   output logic                     Busy,
   output logic                     Done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] SIDE_MAX =
      COUNT_WIDTH'(GRID_SIDE - 1);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX =
      ADDRESS_WIDTH'(GRID_DIM - 1);

   state_t                   state_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [ADDRESS_WIDTH-1:0] addr_d;
   logic [COUNT_WIDTH-1:0]   row_q;
   logic [COUNT_WIDTH-1:0]   row_d;
   logic [COUNT_WIDTH-1:0]   col_q;
   logic [COUNT_WIDTH-1:0]   col_d;
   logic                     valid_q;
   logic                     last_q;
   logic                     last_d;
   logic                     busy_q;
   logic                     done_q;
   logic                     col_end;

   // Next position after a transfer; the linear address is a plain
   // counter kept in lock-step with row/col, so no multiplier.
   always_comb begin
      col_end = (col_q == SIDE_MAX);
      addr_d  = addr_q + ADDRESS_WIDTH'(1);
      col_d   = col_end ? '0 : col_q + COUNT_WIDTH'(1);
      row_d   = col_end ? row_q + COUNT_WIDTH'(1) : row_q;
      last_d  = (addr_d == ADDR_MAX);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (Start) begin
                  state_q <= SCAN;
                  addr_q  <= '0;
                  row_q   <= '0;
                  col_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  last_q  <= (ADDR_MAX == '0);
               end
            end
            SCAN: begin
               if (Ready_in) begin
                  if (last_q) begin
                     state_q <= FIN;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q <= addr_d;
                     row_q  <= row_d;
                     col_q  <= col_d;
                     last_q <= last_d;
                  end
               end
            end
            FIN: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Valid_out = valid_q;
   assign Addr_out  = addr_q;
   assign Row_out   = row_q;
   assign Col_out   = col_q;
   assign Last_out  = last_q;
   assign Busy      = busy_q;
   assign Done      = done_q;

endmodule

// File: tb/tb_grid_addr_gen.sv
// Randomised bench for grid_addr_gen against a raster-scan
// reference model and a per-scan address scoreboard.
module tb_grid_addr_gen;

   localparam int SIDE = 16;
   localparam int DIM  = SIDE * SIDE;
   localparam int AW   = $clog2(DIM);
   localparam int CW   = $clog2(DIM / SIDE);

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic          Ready_in;
   logic          Valid_out;
   logic [AW-1:0] Addr_out;
   logic [CW-1:0] Row_out;
   logic [CW-1:0] Col_out;
   logic          Last_out;
   logic          Busy;
   logic          Done;

   grid_addr_gen #(
      .GRID_DIM (DIM),
      .GRID_SIDE(SIDE)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Ready_in (Ready_in),
      .Valid_out(Valid_out),
      .Addr_out (Addr_out),
      .Row_out  (Row_out),
      .Col_out  (Col_out),
      .Last_out (Last_out),
      .Busy     (Busy),
      .Done     (Done)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference: 0 idle, 1 scanning node m_n, 2 done pulse
   int m_st = 0;
   int m_n  = 0;
   int xq[$];
   logic pv = 1'b0;
   logic pr = 1'b0;
   logic [AW-1:0] pa = '0;
   int valid_cnt = 0;
   int done_cnt  = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic scan_check();
      int bad = 0;
      chk("scan_len", xq.size(), DIM);
      foreach (xq[i]) if (xq[i] != i) bad++;
      chk("scan_order", bad, 0);
      xq.delete();
   endtask

   task automatic compare();
      chk("valid", Valid_out, m_st == 1);
      chk("busy", Busy, m_st == 1);
      chk("done", Done, m_st == 2);
      if (m_st == 1) begin
         chk("addr", Addr_out, m_n);
         chk("row", Row_out, m_n / SIDE);
         chk("col", Col_out, m_n % SIDE);
         chk("last", Last_out, m_n == DIM - 1);
      end else begin
         chk("last_idle", Last_out, 0);
      end
      if (pv && !pr && Valid_out)
         chk("hold", Addr_out, pa);
      valid_cnt += int'(Valid_out);
      done_cnt  += int'(Done);
   endtask

   task automatic cyc();
      logic s, r;
      s = Start;
      r = Ready_in;
      if (Valid_out && Ready_in) xq.push_back(int'(Addr_out));
      pv = Valid_out;
      pr = Ready_in;
      pa = Addr_out;
      @(posedge Clk);
      case (m_st)
         0: if (s) begin m_st = 1; m_n = 0; end
         1: if (r) begin
               if (m_n == DIM - 1) begin
                  m_st = 2;
                  scan_check();
               end else m_n++;
            end
         default: m_st = 0;
      endcase
      @(negedge Clk);
      compare();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit seen;
      Reset = 1'b0;
      Start = 1'b0;
      Ready_in = 1'b0;
      #3;
      chk("rst_valid", Valid_out, 0);
      chk("rst_addr", Addr_out, 0);
      chk("rst_row", Row_out, 0);
      chk("rst_col", Col_out, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_last", Last_out, 0);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) cyc();

      // Full-rate scan and Start-to-IDLE latency
      valid_cnt = 0;
      done_cnt = 0;
      Start = 1'b1;
      Ready_in = 1'b1;
      cyc();
      Start = 1'b0;
      cnt = 1;
      seen = 0;
      do begin
         cyc();
         cnt++;
         if (Done) seen = 1;
      end while (!(seen && !Done && !Busy) && cnt < 400);
      chk("t1_cycles", cnt, 258);
      chk("t1_valid", valid_cnt, DIM);
      chk("t1_done", done_cnt, 1);

      // Ready toggling every cycle
      valid_cnt = 0;
      Start = 1'b1;
      Ready_in = 1'b1;
      cyc();
      Start = 1'b0;
      Ready_in = 1'b0;
      cnt = 0;
      do begin
         cyc();
         Ready_in = ~Ready_in;
         cnt++;
      end while (m_st != 0 && cnt < 700);
      chk("t2_valid", valid_cnt, 2 * DIM);

      // Random backpressure; stray Start pulses mid-scan
      Start = 1'b1;
      Ready_in = 1'($urandom_range(0, 1));
      cyc();
      cnt = 0;
      do begin
         Ready_in = 1'($urandom_range(0, 1));
         Start = (m_st == 1) &&
                 ((Valid_out && Addr_out == 100) ||
                  ($urandom_range(0, 15) == 0));
         cyc();
         cnt++;
      end while (m_st != 0 && cnt < 3000);
      Start = 1'b0;
      chk("t3_end", m_st, 0);

      // Asynchronous reset at address 50
      Start = 1'b1;
      Ready_in = 1'b1;
      cyc();
      Start = 1'b0;
      cnt = 0;
      while (!(Valid_out && Addr_out == 50) && cnt < 100) begin
         cyc();
         cnt++;
      end
      chk("t4_reach50", Addr_out, 50);
      Reset = 1'b0;
      #1;
      chk("t4_valid", Valid_out, 0);
      chk("t4_addr", Addr_out, 0);
      chk("t4_busy", Busy, 0);
      chk("t4_last", Last_out, 0);
      m_st = 0;
      m_n = 0;
      xq.delete();
      pv = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      repeat (5) cyc();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      chk("t4_restart", Addr_out, 0);
      cnt = 0;
      do begin
         cyc();
         cnt++;
      end while (m_st != 0 && cnt < 400);
      chk("t4_end", m_st, 0);

      // Start held high: back-to-back scans
      valid_cnt = 0;
      done_cnt = 0;
      Start = 1'b1;
      Ready_in = 1'b1;
      repeat (516) cyc();
      Start = 1'b0;
      chk("t5_done", done_cnt, 2);
      chk("t5_valid", valid_cnt, 2 * DIM);
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
